game_score_timer: RTL
=====================

// Module: game_score_timer
// PURPOSE
//  Basketball game-state core that drives the 6-digit display multiplexer.
//  Holds the game clock (MM:SS), the 24 s shot clock and the team A/B scores in BCD.
//  Outputs registered 8-bit segment codes: time1..time6 and mark_a1..3 / mark_b1..3.
//  Control and point inputs arrive as debounced single-cycle pulses.
// PARAMETERS
//  CLK_DIV    50_000_000  clock cycles per 1 s tick
//  GAME_MIN   12          game clock start value in minutes (BCD-loaded, 1..99)
//  SHOT_INIT  24          shot clock reload value in seconds (1..99)
// PORTS
//  clock      in   1  system clock
//  rst_n      in   1  synchronous active-low reset
//  start_p    in   1  pulse: toggles run/pause
//  add_a      in   2  pulse value: points for A (0 = none, 1..3)
//  add_b      in   2  pulse value: points for B (0 = none, 1..3)
//  time1..6   out  8  segments: 1/2 = min tens/ones, 3/4 = sec tens/ones, 5/6 = shot tens/ones
//  mark_a1..3 out  8  segments: A score hundreds/tens/ones
//  mark_b1..3 out  8  segments: B score hundreds/tens/ones
//  running    out  1  high while in RUN
//  buzzer     out  1  1-cycle pulse on game end or shot-clock expiry
// BEHAVIOUR
//  Only clock drives the block; reset is synchronous, active-low (rst_n).
//  Segment code is active-low: bit7 = dp, bits6:0 = g..a, 1 = off, 8'hFF = blank.
//  Digit codes 0..9: C0 F9 A4 B0 99 92 82 F8 80 90. time2 has dp lit (bit7 = 0).
//  Reset: state IDLE; min = GAME_MIN; sec = 00; shot = SHOT_INIT; scores 000; div_cnt 0.
//  Reset outputs: running 0, buzzer 0; segment outputs encode the reset values.
//  Reset is honoured mid-run, with or without a pending tick.
//  FSM: IDLE -start_p-> RUN (div_cnt cleared). RUN -start_p-> PAUSE. PAUSE -start_p-> RUN.
//  FSM: RUN -game 00:00-> OVER. OVER is left only by reset; start_p is ignored in OVER.
//  Prescaler: counts only in RUN and holds in PAUSE; tick when div_cnt == CLK_DIV-1, then wraps to 0.
//  On tick: sec decrements; 00 wraps to 59 with min-1; shot decrements.
//  Game 00:00 reached: -> OVER, buzzer pulse.
//  Shot 00 reached, game not ended: -> PAUSE, shot reloads to SHOT_INIT, buzzer pulse.
//  If both reach 0 on the same tick, game end wins: OVER, one buzzer pulse.
//  Points: accepted in IDLE, RUN and PAUSE; ignored in OVER.
//  Points: BCD add with carry across digits; score saturates at 999.
//  Points: any nonzero add_a/add_b reloads shot to SHOT_INIT.
//  add_a and add_b in the same cycle: both applied.
//  Tick and points in the same cycle: score applied; shot reload overrides the decrement.
//  start_p in the same cycle as the expiry tick: expiry wins (PAUSE).
//  Counters update on the cycle of the event.
//  Segment outputs and running are registered: 1-cycle latency after a counter/state change.
//  buzzer is registered and aligned with the state change.
// CONFIGURATION
//  SHOT_CLOCK_EN defined: shot clock present as described.
//  SHOT_CLOCK_EN undefined: no shot logic; time5/time6 = 8'hFF; buzzer only at game end.
// TESTING
//  CLK_DIV=4, GAME_MIN=1, SHOT_INIT=24 unless stated.
//  Reset -> time1..4 = C0 79 C0 C0 (0 1. 0 0); time5/6 = A4 99; all marks C0; running 0.
//  start_p, 4 clk -> sec 59, min 0, shot 23; start_p -> PAUSE; 20 clk idle -> no change.
//  add_a=3 at score 998 -> A = 999 (90 90 90); add_b=2 same cycle -> B = 002; shot reloads to 24.
//  SHOT_INIT=3, run 3 ticks -> buzzer 1 cycle, PAUSE, shot shows 03, game 00:57.
//  Run to 00:00 -> OVER, buzzer once; then start_p and add_a ignored.
//  rst_n low mid-RUN at the tick cycle -> all reset values next cycle; SHOT_CLOCK_EN off -> time5/6 = FF.

Source files
------------

// File: rtl/game_score_timer.sv
// game_score_timer
//   Basketball game-state core feeding a 6-digit display multiplexer. It keeps
//   the game clock (MM:SS), the shot clock and the team A/B scores as BCD
//   digits, and presents every digit as a registered active-low segment code
//   (bit7 = dp, bits6:0 = g..a, 8'hFF = blank).
//
//   Build option: define SHOT_CLOCK_EN to include the shot clock. Without it
//   there is no shot logic, time5/time6 show blank and the buzzer only marks
//   the end of the game.
//
// Ports
//   clock              system clock
//   rst_n              synchronous active-low reset
//   start_p            single-cycle pulse, toggles run/pause
//   add_a, add_b       single-cycle point values (0 = none, 1..3)
//   time1..time6       min tens/ones (time2 dp lit), sec tens/ones, shot tens/ones
//   mark_a1..mark_a3   team A score hundreds/tens/ones
//   mark_b1..mark_b3   team B score hundreds/tens/ones
//   running            high while the game clock runs (registered)
//   buzzer             one-cycle pulse at game end or shot-clock expiry
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset, clocks loaded, waiting for the first start_p
// S_RUN   | prescaler counting, clocks decrement once per tick
// S_PAUSE | clocks and prescaler frozen, points still accepted
// S_OVER  | game clock reached 00:00, only reset leaves this state
module game_score_timer #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int GAME_MIN  = 12,
  parameter int SHOT_INIT = 24
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic [1:0] add_a,
  input  logic [1:0] add_b,
  output logic [7:0] time1,
  output logic [7:0] time2,
  output logic [7:0] time3,
  output logic [7:0] time4,
  output logic [7:0] time5,
  output logic [7:0] time6,
  output logic [7:0] mark_a1,
  output logic [7:0] mark_a2,
  output logic [7:0] mark_a3,
  output logic [7:0] mark_b1,
  output logic [7:0] mark_b2,
  output logic [7:0] mark_b3,
  output logic       running,
  output logic       buzzer
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       MIN_T    = 4'(GAME_MIN / 10);
  localparam logic [3:0]       MIN_O    = 4'(GAME_MIN % 10);
`ifdef SHOT_CLOCK_EN
  localparam logic [3:0]       SHOT_T   = 4'(SHOT_INIT / 10);
  localparam logic [3:0]       SHOT_O   = 4'(SHOT_INIT % 10);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_OVER
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       min_t, min_o, sec_t, sec_o;
  logic [3:0]       min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;
  logic [11:0]      score_a, score_b, score_a_nxt, score_b_nxt;
  logic             buzz_nxt;
  logic             tick;
  logic             pts;
  logic             game_last;
  logic             shot_expire;
`ifdef SHOT_CLOCK_EN
  logic [3:0]       shot_t, shot_o, shot_t_nxt, shot_o_nxt;
  logic             shot_last;
`endif

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Three-digit BCD add of a 0..3 value; a carry out of the hundreds digit
  // means the true sum passed 999, so the score pins at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [1:0] v);
    logic [4:0] o, t, h;
    o = {1'b0, s[3:0]} + {3'b000, v};
    t = {1'b0, s[7:4]};
    h = {1'b0, s[11:8]};
    if (o > 5'd9) begin
      o = o - 5'd10;
      t = t + 5'd1;
    end
    if (t > 5'd9) begin
      t = t - 5'd10;
      h = h + 5'd1;
    end
    if (h > 5'd9) return 12'h999;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  assign tick      = (state == S_RUN) && (div_cnt == DIV_LAST);
  assign pts       = (state != S_OVER) && ((add_a != 2'd0) || (add_b != 2'd0));
  assign game_last = (min_t == 4'd0) && (min_o == 4'd0) && (sec_t == 4'd0) && (sec_o == 4'd1);

`ifdef SHOT_CLOCK_EN
  assign shot_last = (shot_t == 4'd0) && (shot_o == 4'd1);
  // A point scored on the expiry tick reloads the shot clock first, so it
  // never reaches zero; game end also takes priority over expiry.
  assign shot_expire = tick && shot_last && !pts && !game_last;
`else
  assign shot_expire = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    min_t_nxt   = min_t;
    min_o_nxt   = min_o;
    sec_t_nxt   = sec_t;
    sec_o_nxt   = sec_o;
    score_a_nxt = score_a;
    score_b_nxt = score_b;
    buzz_nxt    = 1'b0;
`ifdef SHOT_CLOCK_EN
    shot_t_nxt  = shot_t;
    shot_o_nxt  = shot_o;
`endif

    if (state == S_RUN) div_nxt = tick ? '0 : div_cnt + 1'b1;

    if (pts) begin
      score_a_nxt = bcd_add(score_a, add_a);
      score_b_nxt = bcd_add(score_b, add_b);
    end

    if (tick) begin
      if (sec_o != 4'd0) begin
        sec_o_nxt = sec_o - 4'd1;
      end else begin
        sec_o_nxt = 4'd9;
        if (sec_t != 4'd0) begin
          sec_t_nxt = sec_t - 4'd1;
        end else begin
          sec_t_nxt = 4'd5;
          if (min_o != 4'd0) begin
            min_o_nxt = min_o - 4'd1;
          end else begin
            min_o_nxt = 4'd9;
            min_t_nxt = min_t - 4'd1;
          end
        end
      end
`ifdef SHOT_CLOCK_EN
      if (shot_o != 4'd0) begin
        shot_o_nxt = shot_o - 4'd1;
      end else begin
        shot_o_nxt = 4'd9;
        shot_t_nxt = shot_t - 4'd1;
      end
`endif
    end

`ifdef SHOT_CLOCK_EN
    if (pts || shot_expire) begin
      shot_t_nxt = SHOT_T;
      shot_o_nxt = SHOT_O;
    end
`endif

    case (state)
      S_IDLE: begin
        if (start_p) begin
          state_nxt = S_RUN;
          div_nxt   = '0;
        end
      end
      S_RUN: begin
        if (tick && game_last) begin
          state_nxt = S_OVER;
          buzz_nxt  = 1'b1;
        end else if (shot_expire) begin
          state_nxt = S_PAUSE;
          buzz_nxt  = 1'b1;
        end else if (start_p) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_p) state_nxt = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      min_t   <= MIN_T;
      min_o   <= MIN_O;
      sec_t   <= 4'd0;
      sec_o   <= 4'd0;
      score_a <= 12'h000;
      score_b <= 12'h000;
      buzzer  <= 1'b0;
`ifdef SHOT_CLOCK_EN
      shot_t  <= SHOT_T;
      shot_o  <= SHOT_O;
`endif
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      min_t   <= min_t_nxt;
      min_o   <= min_o_nxt;
      sec_t   <= sec_t_nxt;
      sec_o   <= sec_o_nxt;
      score_a <= score_a_nxt;
      score_b <= score_b_nxt;
      buzzer  <= buzz_nxt;
`ifdef SHOT_CLOCK_EN
      shot_t  <= shot_t_nxt;
      shot_o  <= shot_o_nxt;
`endif
    end
  end

  // Display registers: under reset they load the encoded reset values
  // directly so the display is correct on the first cycle out of reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      time1   <= seg_enc(MIN_T);
      time2   <= seg_enc(MIN_O) & 8'h7F;
      time3   <= seg_enc(4'd0);
      time4   <= seg_enc(4'd0);
`ifdef SHOT_CLOCK_EN
      time5   <= seg_enc(SHOT_T);
      time6   <= seg_enc(SHOT_O);
`else
      time5   <= 8'hFF;
      time6   <= 8'hFF;
`endif
      mark_a1 <= seg_enc(4'd0);
      mark_a2 <= seg_enc(4'd0);
      mark_a3 <= seg_enc(4'd0);
      mark_b1 <= seg_enc(4'd0);
      mark_b2 <= seg_enc(4'd0);
      mark_b3 <= seg_enc(4'd0);
      running <= 1'b0;
    end else begin
      time1   <= seg_enc(min_t);
      time2   <= seg_enc(min_o) & 8'h7F;
      time3   <= seg_enc(sec_t);
      time4   <= seg_enc(sec_o);
`ifdef SHOT_CLOCK_EN
      time5   <= seg_enc(shot_t);
      time6   <= seg_enc(shot_o);
`else
      time5   <= 8'hFF;
      time6   <= 8'hFF;
`endif
      mark_a1 <= seg_enc(score_a[11:8]);
      mark_a2 <= seg_enc(score_a[7:4]);
      mark_a3 <= seg_enc(score_a[3:0]);
      mark_b1 <= seg_enc(score_b[11:8]);
      mark_b2 <= seg_enc(score_b[7:4]);
      mark_b3 <= seg_enc(score_b[3:0]);
      running <= (state == S_RUN);
    end
  end

endmodule
